// File: rtl/i_softmax_row.sv
// Row softmax engine: buffers a score row, finds the max, sums integer exp terms, then
// normalises each term with a serial divider. Optional macro ISOFTMAX_EXP_BUF_EN keeps exp results in the buffer.
`timescale 1ns/1ps
module i_softmax_row #(
    parameter int DW        = 32,
    parameter int N_MAX     = 64,
    parameter int OUT_FRAC  = 8,
    localparam int LW       = $clog2(N_MAX) + 1,
    localparam int OUT_W    = OUT_FRAC + 1,
    localparam int AW       = DW + $clog2(N_MAX)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [DW-1:0]    q_b,
    input  logic [DW-1:0]    q_c,
    input  logic [DW-1:0]    q_ln2,
    input  logic [LW-1:0]    row_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam int IW = $clog2(N_MAX);
    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EXP, NORM, OUT} state_t;
    state_t state, state_next;

    logic [DW-1:0]    mem [N_MAX];
    logic [LW-1:0]    len, idx;
    logic [DW-1:0]    b_r, c_r, ln2_r, max_r;
    logic [AW-1:0]    acc, rem, diff;
    logic [OUT_W-2:0] quo;
    logic [CW-1:0]    cnt;
    logic [AW:0]      trial;
    logic             in_fire, len_bad, start_row, idx_last, norm_done, ge;
    logic [DW-1:0]    rd_data, e_cur, e_norm, wr_data;
    logic [IW-1:0]    wr_addr;
    logic             wr_en;

    function automatic logic [DW-1:0] exp_int(input logic [DW-1:0] x, input logic [DW-1:0] mx,
                                              input logic [DW-1:0] b, input logic [DW-1:0] c,
                                              input logic [DW-1:0] ln2);
        logic [DW-1:0] d, z, p, ql;
        d  = x - mx;
        z  = (-d) / ln2;
        p  = d + z * ln2;
        ql = (p + b) * p + c;
        if (ql[DW-1] || (z >= DW'(DW - 1)))
            return '0;
        return ql >> z;
    endfunction

    always_comb begin
        in_fire   = in_valid && in_ready;
        len_bad   = (row_len == '0) || (row_len > LW'(N_MAX));
        start_row = (state == IDLE) && in_fire && !len_bad;
        idx_last  = (idx == len - LW'(1));
        norm_done = (cnt == CW'(OUT_W - 1));
        rd_data   = mem[idx[IW-1:0]];
        e_cur     = exp_int(rd_data, max_r, b_r, c_r, ln2_r);
`ifdef ISOFTMAX_EXP_BUF_EN
        e_norm    = rd_data;
`else
        e_norm    = e_cur;
`endif
        // First divider step takes e unshifted: e <= acc, so quotient bit OUT_FRAC is (e >= acc).
        trial = (cnt == '0) ? {{(AW + 1 - DW){1'b0}}, e_norm} : {rem, 1'b0};
        ge    = (trial >= {1'b0, acc});
        diff  = trial[AW-1:0] - acc;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx[IW-1:0];
        wr_data = in_data;
        case (state)
            IDLE: begin
                wr_en   = start_row;
                wr_addr = '0;
            end
            LOAD: wr_en = in_fire;
`ifdef ISOFTMAX_EXP_BUF_EN
            EXP: begin
                wr_en   = 1'b1;
                wr_data = e_cur;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        out_valid  = (state == OUT);
        out_last   = (state == OUT) && idx_last;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (start_row) state_next = (row_len == LW'(1)) ? EXP : LOAD;
            LOAD: if (in_fire && idx_last) state_next = EXP;
            EXP:  if (idx_last) state_next = NORM;
            NORM: if (norm_done) state_next = OUT;
            OUT:  if (out_ready) state_next = idx_last ? IDLE : NORM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            in_ready <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
            idx      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            ln2_r    <= '0;
            max_r    <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            in_ready <= (state_next == IDLE) || (state_next == LOAD);
            err      <= (state == IDLE) && in_fire && len_bad;
            case (state)
                IDLE: if (start_row) begin
                    len   <= row_len;
                    b_r   <= q_b;
                    c_r   <= q_c;
                    ln2_r <= q_ln2;
                    max_r <= in_data;
                    acc   <= '0;
                    idx   <= (row_len == LW'(1)) ? '0 : LW'(1);
                end
                LOAD: if (in_fire) begin
                    if ($signed(in_data) > $signed(max_r))
                        max_r <= in_data;
                    idx <= idx_last ? '0 : idx + LW'(1);
                end
                EXP: begin
                    acc <= acc + {{(AW - DW){1'b0}}, e_cur};
                    idx <= idx_last ? '0 : idx + LW'(1);
                end
                NORM: begin
                    rem <= ge ? diff : trial[AW-1:0];
                    quo <= {quo[OUT_W-3:0], ge};
                    cnt <= norm_done ? '0 : cnt + CW'(1);
                    if (norm_done)
                        out_data <= (acc == '0) ? '0 : {quo, ge};
                end
                OUT: if (out_ready) idx <= idx_last ? '0 : idx + LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i_softmax_row.sv
// Self-checking bench for i_softmax_row: fixed vectors, corner sequences and random rows vs a reference model.
`timescale 1ns/1ps
module tb_i_softmax_row;
    localparam int DW       = 32;
    localparam int N_MAX    = 64;
    localparam int OUT_FRAC = 8;
    localparam int LW       = 7;
    localparam int OUT_W    = OUT_FRAC + 1;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b0;
    logic [DW-1:0]    q_b = '0, q_c = '0, q_ln2 = '0;
    logic [LW-1:0]    row_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             err;

    i_softmax_row #(.DW(DW), .N_MAX(N_MAX), .OUT_FRAC(OUT_FRAC)) dut (
        .CLK(CLK), .RST_n(RST_n), .q_b(q_b), .q_c(q_c), .q_ln2(q_ln2), .row_len(row_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int sc[64], ex[64], got[64], gl[64], vcyc[64], saved[64];
    int hs_cyc;
    int cb, cc, cl;

    typedef struct {
        int len;
        int b;
        int c;
        int ln2;
        int sc[4];
        int ex[4];
    } vec_t;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint ref_exp(input int x, input int mx, input int b, input int c, input int ln2);
        longint d, z, p;
        int ql;
        d  = longint'(x) - longint'(mx);
        z  = (-d) / ln2;
        p  = d + z * ln2;
        ql = int'((p + b) * p + c);
        if (ql < 0 || z >= DW - 1)
            return 0;
        return longint'(ql) >> z;
    endfunction

    function automatic void model_row(input int n);
        int mx;
        longint e[64];
        longint acc;
        mx = sc[0];
        for (int i = 1; i < n; i++)
            if (sc[i] > mx) mx = sc[i];
        acc = 0;
        for (int i = 0; i < n; i++) begin
            e[i] = ref_exp(sc[i], mx, cb, cc, cl);
            acc += e[i];
        end
        for (int i = 0; i < n; i++)
            ex[i] = (acc == 0) ? 0 : int'((e[i] * (longint'(1) << OUT_FRAC)) / acc);
    endfunction

    task automatic send_row(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_data  = sc[i];
            if (i == 0) begin
                row_len = n[LW-1:0];
                q_b = cb; q_c = cc; q_ln2 = cl;
            end
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 50) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
            hs_cyc = cyc;
            if (i == 0) begin
                // Latched values must be used for the rest of the row.
                row_len = LW'($urandom);
                q_b = $urandom; q_c = $urandom; q_ln2 = $urandom | 32'd1;
            end
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic recv_row(input int n, input bit stall);
        int t;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!out_valid && t < 300) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 300) begin
                chk("out_valid_timeout", k, n);
                return;
            end
            vcyc[k] = cyc;
            got[k]  = int'(out_data);
            gl[k]   = int'(out_last);
            if (stall && (k % 2 == 1)) begin
                out_ready = 1'b0;
                repeat (2) begin
                    @(negedge CLK);
                    chk("hold_valid", longint'(out_valid), 1);
                    chk("hold_data", longint'(out_data), got[k]);
                    chk("hold_last", longint'(out_last), gl[k]);
                end
                out_ready = 1'b1;
            end
            @(posedge CLK);
            #1;
            @(negedge CLK);
            chk("valid_drop_after_hs", longint'(out_valid), 0);
        end
    endtask

    task automatic run_row(input string tag, input int n, input bit stall);
        send_row(n);
        recv_row(n, stall);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_data"}, got[k], ex[k]);
            chk({tag, "_last"}, gl[k], longint'(k == n - 1));
        end
        chk({tag, "_latency"}, vcyc[0] - hs_cyc + 1, n + OUT_W + 1);
        if (!stall)
            for (int k = 1; k < n; k++)
                chk({tag, "_spacing"}, vcyc[k] - vcyc[k-1], OUT_W + 1);
        chk({tag, "_idle_busy"}, longint'(busy), 0);
        chk({tag, "_idle_ready"}, longint'(in_ready), 1);
    endtask

    task automatic bad_len(input int l);
        @(negedge CLK);
        in_valid = 1'b1;
        row_len  = l[LW-1:0];
        in_data  = 32'd123;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("err_pulse", longint'(err), 1);
        chk("err_busy", longint'(busy), 0);
        @(negedge CLK);
        chk("err_clear", longint'(err), 0);
        chk("err_no_valid", longint'(out_valid), 0);
        chk("err_stay_idle", longint'(busy), 0);
        chk("err_ready", longint'(in_ready), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{len:4, b:0,  c:1000, ln2:10, sc:'{5, 5, 5, 5},       ex:'{64, 64, 64, 64}};
        tbl[1] = '{len:2, b:0,  c:1000, ln2:10, sc:'{100, 0, 0, 0},     ex:'{256, 0, 0, 0}};
        tbl[2] = '{len:2, b:0,  c:1000, ln2:10, sc:'{7, 7, 0, 0},       ex:'{128, 128, 0, 0}};
        tbl[3] = '{len:3, b:0,  c:1000, ln2:10, sc:'{0, -10, -20, 0},   ex:'{146, 73, 36, 0}};
        tbl[4] = '{len:2, b:0,  c:1000, ln2:10, sc:'{0, -5, 0, 0},      ex:'{126, 129, 0, 0}};
        tbl[5] = '{len:2, b:10, c:10,   ln2:10, sc:'{0, -5, 0, 0},      ex:'{256, 0, 0, 0}};
        tbl[6] = '{len:1, b:0,  c:500,  ln2:10, sc:'{-50, 0, 0, 0},     ex:'{256, 0, 0, 0}};
        tbl[7] = '{len:3, b:0,  c:1000, ln2:10, sc:'{-30, -10, -20, 0}, ex:'{36, 146, 73, 0}};

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_err", longint'(err), 0);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_in_ready", longint'(in_ready), 1);

        for (int v = 0; v < 8; v++) begin
            cb = tbl[v].b; cc = tbl[v].c; cl = tbl[v].ln2;
            for (int i = 0; i < tbl[v].len; i++) begin
                sc[i] = tbl[v].sc[i];
                ex[i] = tbl[v].ex[i];
            end
            run_row($sformatf("vec%0d", v), tbl[v].len, 1'b0);
        end

        bad_len(0);
        bad_len(N_MAX + 1);

        // Backpressure: same row with and without stalls
        cb = 0; cc = 1000; cl = 10;
        sc[0] = 0; sc[1] = -10; sc[2] = -20;
        ex[0] = 146; ex[1] = 73; ex[2] = 36;
        run_row("nostall", 3, 1'b0);
        for (int k = 0; k < 3; k++) saved[k] = got[k];
        run_row("stall", 3, 1'b1);
        for (int k = 0; k < 3; k++) chk("stall_vs_nostall", got[k], saved[k]);

        // Reset during NORM of element 1
        sc[0] = 1; sc[1] = 2; sc[2] = 3;
        send_row(3);
        recv_row(1, 1'b0);
        chk("pre_rst_last", gl[0], 0);
        #2;
        RST_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("postrst_no_valid", longint'(out_valid), 0);
        sc[0] = 7; sc[1] = 7;
        ex[0] = 128; ex[1] = 128;
        run_row("after_rst", 2, 1'b0);

        // Random rows against the reference model
        for (int r = 0; r < 6; r++) begin
            int n;
            n  = (r == 0) ? N_MAX : int'($urandom_range(N_MAX, 1));
            cb = int'($urandom_range(200, 0)) - 100;
            cc = int'($urandom_range(100000, 1000));
            cl = int'($urandom_range(200, 20));
            for (int i = 0; i < n; i++)
                sc[i] = int'($urandom_range(4000, 0)) - 2000;
            model_row(n);
            run_row($sformatf("rand%0d", r), n, r == 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
